// File: rtl/fetch_unit.sv
// Instruction fetch front end: 2-entry in-order {inst, pc} buffer feeding decode, with redirect and halt control.
// Optional misaligned-redirect trap is built when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   output logic        o_fetch_trap
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 2;
   localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
   localparam logic [XLEN-1:0] STEP       = 32'd4;
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } entry_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   entry_t          head_q, head_d;
   entry_t          tail_q, tail_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   stale_q, stale_d;
   logic            trap_q, trap_d;

   logic            pop_c;
   logic            accept_c;
   logic            rsp_c;
   logic            push_c;
   logic            misalign_c;
   logic [XLEN-1:0] target_c;
   logic [CW-1:0]   cnt_pop_c;
   logic [CW:0]     commit_c;

   // Redirect target qualification
   always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
      target_c   = i_redirect_pc;
      misalign_c = |i_redirect_pc[1:0];
`else
      target_c   = i_redirect_pc & ALIGN_MASK;
      misalign_c = 1'b0;
`endif
   end

   assign o_valid      = (cnt_q != '0);
   assign o_inst       = o_valid ? head_q.inst : NOP;
   assign o_pc         = o_valid ? head_q.pc : pc_q;
   assign o_pc_plus4   = o_pc + STEP;
   assign o_imem_addr  = pc_q;
   assign o_fetch_trap = trap_q;

   // A head leaving this cycle frees its slot, which is what allows one instruction per cycle.
   assign pop_c      = o_valid & ~i_stall & ~i_redirect;
   assign commit_c   = (CW+1)'(cnt_q) + (CW+1)'(out_q) - (CW+1)'(pop_c);
   assign o_imem_req = (state_q == ST_RUN) & ~i_redirect & (commit_c < (CW+1)'(2));
   assign accept_c   = o_imem_req & i_imem_ready;
   assign rsp_c      = i_imem_rvalid & (out_q != '0);
   assign push_c     = rsp_c & (stale_q == '0) & ~i_redirect;
   assign cnt_pop_c  = cnt_q - CW'(pop_c);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_pop_c;
      out_d    = out_q + CW'(accept_c) - CW'(rsp_c);
      stale_d  = stale_q;
      trap_d   = trap_q;

      if (pop_c) begin
         head_d = tail_q;
      end
      if (push_c && (cnt_pop_c < CW'(2))) begin
         if (cnt_pop_c == '0) begin
            head_d = '{inst: i_imem_rdata, pc: rsp_pc_q};
         end else begin
            tail_d = '{inst: i_imem_rdata, pc: rsp_pc_q};
         end
         cnt_d = cnt_pop_c + CW'(1);
      end
      if (push_c) begin
         rsp_pc_d = rsp_pc_q + STEP;
      end
      if (accept_c) begin
         pc_d = pc_q + STEP;
      end
      if (rsp_c && (stale_q != '0)) begin
         stale_d = stale_q - CW'(1);
      end

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (i_halt && !i_redirect) state_d = ST_HALT;
         ST_HALT: if (i_redirect) state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase

      // Redirect wins over stall and halt; everything still in flight becomes stale.
      if (i_redirect) begin
         cnt_d    = '0;
         pc_d     = target_c;
         rsp_pc_d = target_c;
         stale_d  = out_d;
         trap_d   = misalign_c;
         if (misalign_c) begin
            state_d = ST_HALT;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         stale_q  <= '0;
         trap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         stale_q  <= stale_d;
         trap_q   <= trap_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run compared every cycle against a queue-based reference model and a latency memory model.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, redir, halt, ready, rvalid;
   logic [31:0] rpc, rdata;
   logic        o_imem_req, o_valid, o_fetch_trap;
   logic [31:0] o_imem_addr, o_inst, o_pc, o_pc_plus4;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ready  (ready),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .o_valid       (o_valid),
      .o_inst        (o_inst),
      .o_pc          (o_pc),
      .o_pc_plus4    (o_pc_plus4),
      .i_stall       (stall),
      .i_redirect    (redir),
      .i_redirect_pc (rpc),
      .i_halt        (halt),
      .o_fetch_trap  (o_fetch_trap)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%08h want=%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h0000_0104) ? 32'h0050_0093 : {8'hA5, a[23:0]};
   endfunction

   // Memory model: in-order queue of accepted addresses with a due cycle
   typedef struct {logic [31:0] addr; int due;} mreq_t;
   mreq_t mq[$];
   int    cyc = 0;
   int    lat = 1;
   bit    spur = 0;

   // Reference model: decode buffer, pending requests tagged stale, fetch pc, mode
   typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
   typedef struct {logic [31:0] pc; bit stale;} pend_t;
   ent_t        mbuf[$];
   pend_t       mpend[$];
   logic [31:0] mfpc = RST_PC;
   int          mst = 0;   // 0 boot, 1 run, 2 halt
   bit          mtrap = 0;

   logic        c_req, c_valid, c_trap;
   logic [31:0] c_addr, c_inst, c_pc, c_pc4;

   task automatic m_reset();
      mbuf.delete();
      mpend.delete();
      mfpc  = RST_PC;
      mst   = 0;
      mtrap = 0;
   endtask

   // One cycle: drive memory response, compare against model, advance at the clock edge
   task automatic step();
      bit          mvalid, mpop, mreq, resp, from_mq, mis;
      int          used;
      logic [31:0] tgt, einst, epc;
      pend_t       r;
      rvalid  = 1'b0;
      rdata   = '0;
      from_mq = 0;
      r       = '{pc: '0, stale: 0};
      if (rst) begin
         m_reset();
         mq.delete();
      end
      if (spur && mq.size() == 0) begin
         rvalid = 1'b1;
         rdata  = 32'hDEAD_BEEF;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
         rvalid  = 1'b1;
         rdata   = memf(mq[0].addr);
         from_mq = 1;
      end
      spur = 0;
      #1;
      mvalid = mbuf.size() > 0;
      mpop   = mvalid && !stall && !redir;
      used   = mbuf.size() + mpend.size() - int'(mpop);
      mreq   = (mst == 1) && !redir && (used < 2);
      einst  = mvalid ? mbuf[0].inst : NOP;
      epc    = mvalid ? mbuf[0].pc : mfpc;
      c_req = o_imem_req; c_addr = o_imem_addr; c_valid = o_valid; c_inst = o_inst;
      c_pc = o_pc; c_pc4 = o_pc_plus4; c_trap = o_fetch_trap;
      check("o_valid", 32'(c_valid), 32'(mvalid));
      check("o_inst", c_inst, einst);
      check("o_pc", c_pc, epc);
      check("o_pc_plus4", c_pc4, epc + 32'd4);
      check("o_imem_req", 32'(c_req), 32'(mreq));
      if (mreq) check("o_imem_addr", c_addr, mfpc);
      check("o_fetch_trap", 32'(c_trap), 32'(mtrap));
      @(posedge clk);
      if (!rst) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = rpc;
         mis = (rpc[1:0] != 2'b00);
`else
         tgt = {rpc[31:2], 2'b00};
         mis = 0;
`endif
         resp = rvalid && mpend.size() > 0;
         if (resp) r = mpend.pop_front();
         if (mpop) void'(mbuf.pop_front());
         if (resp && !r.stale && !redir && mbuf.size() < 2) mbuf.push_back('{inst: rdata, pc: r.pc});
         if (mreq && ready) begin
            mpend.push_back('{pc: mfpc, stale: 0});
            mfpc = mfpc + 32'd4;
         end
         case (mst)
            0: mst = 1;
            1: if (halt && !redir) mst = 2;
            default: if (redir) mst = 1;
         endcase
         if (redir) begin
            mbuf.delete();
            foreach (mpend[i]) mpend[i].stale = 1;
            mfpc  = tgt;
            mtrap = mis;
            if (mis) mst = 2;
         end
      end
      if (from_mq) void'(mq.pop_front());
      if (c_req && ready && !rst) mq.push_back('{addr: c_addr, due: cyc + lat});
      cyc++;
      @(negedge clk);
   endtask

   typedef struct {
      bit          stall;
      bit          halt;
      bit          req;
      logic [31:0] addr;
      bit          valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;
   vec_t tbl[10];

   initial begin
      bit found;
      bit was_rst;
      logic [31:0] a0;

      tbl[0] = '{0, 0, 0, 32'h100, 0, 32'h100, NOP};
      tbl[1] = '{0, 0, 1, 32'h100, 0, 32'h100, NOP};
      tbl[2] = '{0, 0, 1, 32'h104, 0, 32'h104, NOP};
      tbl[3] = '{0, 0, 1, 32'h108, 1, 32'h100, 32'hA500_0100};
      tbl[4] = '{1, 0, 0, 32'h10C, 1, 32'h104, 32'h0050_0093};
      tbl[5] = '{1, 0, 0, 32'h10C, 1, 32'h104, 32'h0050_0093};
      tbl[6] = '{1, 0, 0, 32'h10C, 1, 32'h104, 32'h0050_0093};
      tbl[7] = '{0, 0, 1, 32'h10C, 1, 32'h104, 32'h0050_0093};
      tbl[8] = '{0, 0, 1, 32'h110, 1, 32'h108, 32'hA500_0108};
      tbl[9] = '{0, 1, 1, 32'h114, 1, 32'h10C, 32'hA500_010C};

      rst = 1'b1; stall = 1'b0; redir = 1'b0; halt = 1'b0; ready = 1'b1;
      rvalid = 1'b0; rdata = '0; rpc = '0;
      @(negedge clk);
      step();
      check("rst_req", 32'(c_req), 32'd0);
      check("rst_valid", 32'(c_valid), 32'd0);
      check("rst_inst", c_inst, NOP);
      check("rst_pc", c_pc, RST_PC);
      check("rst_trap", 32'(c_trap), 32'd0);
      rst = 1'b0;

      // Boot, streaming, 3-cycle stall and halt at 0x10C
      for (int i = 0; i < 10; i++) begin
         stall = tbl[i].stall;
         halt  = tbl[i].halt;
         step();
         check($sformatf("tbl%0d_req", i), 32'(c_req), 32'(tbl[i].req));
         check($sformatf("tbl%0d_addr", i), c_addr, tbl[i].addr);
         check($sformatf("tbl%0d_valid", i), 32'(c_valid), 32'(tbl[i].valid));
         check($sformatf("tbl%0d_pc", i), c_pc, tbl[i].pc);
         check($sformatf("tbl%0d_inst", i), c_inst, tbl[i].inst);
      end
      stall = 1'b0; halt = 1'b0;

      for (int i = 0; i < 4; i++) begin
         step();
         check("halt_no_req", 32'(c_req), 32'd0);
      end
      redir = 1'b1; rpc = 32'h40;
      step();
      redir = 1'b0;
      check("redir40_req_low", 32'(c_req), 32'd0);
      step();
      check("resume_req", 32'(c_req), 32'd1);
      check("resume_addr", c_addr, 32'h40);
      step();
      step();
      check("resume_valid", 32'(c_valid), 32'd1);
      check("resume_pc", c_pc, 32'h40);
      check("resume_pc4", c_pc4, 32'h44);

      // Redirect with two requests outstanding
      lat = 3;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (mpend.size() == 2) found = 1;
         else step();
      end
      check("two_outstanding_reached", 32'(found), 32'd1);
      redir = 1'b1; rpc = 32'h200;
      step();
      redir = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (c_valid) found = 1;
      end
      check("redir200_valid_seen", 32'(found), 32'd1);
      check("redir200_pc", c_pc, 32'h200);
      check("redir200_pc4", c_pc4, 32'h204);

      // Memory not ready for 4 cycles
      lat = 1;
      for (int i = 0; i < 10; i++) step();
      ready = 1'b0;
      step();
      a0 = c_addr;
      check("nrdy_req", 32'(c_req), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("nrdy_req_stable", 32'(c_req), 32'd1);
         check("nrdy_addr_stable", c_addr, a0);
      end
      check("nrdy_drained_valid", 32'(c_valid), 32'd0);
      check("nrdy_drained_inst", c_inst, NOP);
      ready = 1'b1;

      // Misaligned redirect target
      for (int i = 0; i < 3; i++) step();
      redir = 1'b1; rpc = 32'h202;
      step();
      redir = 1'b0;
      step();
`ifdef FETCH_MISALIGN_TRAP_EN
      check("mis_trap", 32'(c_trap), 32'd1);
      check("mis_no_req", 32'(c_req), 32'd0);
`else
      check("mis_trap", 32'(c_trap), 32'd0);
      check("mis_req", 32'(c_req), 32'd1);
      check("mis_addr", c_addr, 32'h200);
`endif

      // Randomized traffic, including mid-flight resets and spurious responses
      was_rst = 0;
      for (int i = 0; i < 1500; i++) begin
         stall = ($urandom % 4) == 0;
         ready = ($urandom % 10) < 7;
         halt  = ($urandom % 20) == 0;
         redir = ($urandom % 25) == 0;
         rpc   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
         lat   = $urandom_range(1, 3);
         spur  = (($urandom % 40) == 0) || was_rst;
         rst   = ($urandom % 300) == 0;
         was_rst = rst;
         step();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
